trace_term_monitor: RTL and testbench

Synthesizable, parametrised monitor for the mor1kx execution trace of an N-core OpTiMSoC system. It tracks each core's r3 shadow, decodes l.nop exit and putc, and latches per-core termination and exit codes. It also serialises putc characters from all cores through a round-robin arbiter onto one valid/ready stream, and runs a global watchdog. It sits beside the compute tiles (fed from each tile's `trace` bundle) and generalises the fixed-count simulation-only monitors to any core count, usable on FPGA.

---
 rtl/trace_monitor_pkg.sv | 13 +
 rtl/trace_putc_arb.sv | 55 +++++
 rtl/trace_term_monitor.sv | 172 +++++++++++++++++
 tb/tb_trace_term_monitor.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_monitor_pkg.sv
// Shared constants and l.nop decode helper for the mor1kx trace termination monitor.
package trace_monitor_pkg;

   localparam logic [15:0] NOP_PREFIX = 16'h1500;
   localparam logic [15:0] NOP_EXIT   = 16'h0001;
   localparam logic [15:0] NOP_PUTC   = 16'h0004;
   localparam logic [4:0]  R3_IDX     = 5'd3;

   function automatic logic is_nop(input logic [31:0] insn, input logic [15:0] k);
      return (insn[31:16] == NOP_PREFIX) && (insn[15:0] == k);
   endfunction

endpackage

// File: rtl/trace_putc_arb.sv
// Round-robin arbiter over N request lines; combinational grant, search starts after last_grant.
// Pointer advances only when the caller accepts the grant, so a stalled consumer keeps the order.
module trace_putc_arb
   import trace_monitor_pkg::*;
#(
   parameter  int N  = 4,
   localparam int CW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear_i,
   input  logic [N-1:0]  req_i,
   input  logic          accept_i,
   output logic [N-1:0]  gnt_o,
   output logic [CW-1:0] gnt_idx_o,
   output logic          gnt_vld_o
);

   logic [CW-1:0] last_q;
   logic [CW-1:0] last_d;
   logic          found;
   logic [CW-1:0] sel;

   always_comb begin : search
      int j;
      j     = 0;
      found = 1'b0;
      sel   = '0;
      for (int off = 1; off <= N; off++) begin
         j = int'(last_q) + off;
         if (j >= N) j = j - N;
         if (!found && req_i[j[CW-1:0]]) begin
            found = 1'b1;
            sel   = j[CW-1:0];
         end
      end
   end

   always_comb begin
      gnt_o = '0;
      if (found) gnt_o[sel] = 1'b1;
   end

   assign gnt_idx_o = sel;
   assign gnt_vld_o = found;
   assign last_d    = (accept_i && found) ? sel : last_q;

   // Reset pointer to the last core so that core 0 wins the first search.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       last_q <= CW'(N - 1);
      else if (clear_i) last_q <= CW'(N - 1);
      else              last_q <= last_d;
   end

endmodule

// File: rtl/trace_term_monitor.sv
// Per-core exit/putc trace monitor with watchdog; exit visible 1 cycle after the beat, putc 2 cycles.
// Putc stream is valid/ready; each core buffers one char, further chars are dropped and flagged.
module trace_term_monitor
   import trace_monitor_pkg::*;
#(
   parameter  int NUM_CORES      = 4,
   parameter  int TIMEOUT_CYCLES = 0,
   localparam int CW  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1,
   localparam int DCW = $clog2(NUM_CORES + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clear,
   input  logic [NUM_CORES-1:0]    trace_valid,
   input  logic [NUM_CORES*32-1:0] trace_insn,
   input  logic [NUM_CORES-1:0]    trace_wben,
   input  logic [NUM_CORES*5-1:0]  trace_wbreg,
   input  logic [NUM_CORES*32-1:0] trace_wbdata,
   output logic [NUM_CORES-1:0]    core_done,
   output logic [NUM_CORES*32-1:0] exit_code,
   output logic                    all_done,
   output logic                    any_error,
   output logic [DCW-1:0]          done_count,
   output logic                    timeout,
   output logic                    char_valid,
   input  logic                    char_ready,
   output logic [CW-1:0]           char_core,
   output logic [7:0]              char_data,
   output logic [NUM_CORES-1:0]    putc_overflow
);

   logic [NUM_CORES-1:0] pend;
   logic [NUM_CORES-1:0] err;
   logic [7:0]           pend_dat [NUM_CORES];
   logic [NUM_CORES-1:0] arb_gnt;
   logic [CW-1:0]        arb_idx;
   logic                 arb_vld;
   logic                 load;
   logic                 accept;

   logic                 char_vld_q;
   logic [CW-1:0]        char_core_q;
   logic [7:0]           char_dat_q;
   logic [31:0]          wd_q;
   logic [31:0]          wd_d;
   logic                 timeout_q;
   logic                 wd_run;

   assign load   = !char_vld_q || char_ready;
   assign accept = load && arb_vld;

   for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
      logic [31:0] insn;
      logic        wr_r3;
      logic        exit_ev;
      logic        putc_ev;
      logic        take;
      logic [31:0] r3_q;
      logic [31:0] exit_q;
      logic        done_q;
      logic        pend_q;
      logic        ovf_q;
      logic [7:0]  pdat_q;

      assign insn    = trace_insn[g*32 +: 32];
      assign wr_r3   = trace_valid[g] && trace_wben[g] && (trace_wbreg[g*5 +: 5] == R3_IDX);
      assign exit_ev = trace_valid[g] && is_nop(insn, NOP_EXIT);
      assign putc_ev = trace_valid[g] && is_nop(insn, NOP_PUTC);
      assign take    = accept && arb_gnt[g];

      // l.nop never writes back, so exit/putc always consume the pre-beat shadow.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r3_q   <= '0;
            exit_q <= '0;
            done_q <= 1'b0;
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
            pdat_q <= '0;
         end else if (clear) begin
            r3_q   <= '0;
            exit_q <= '0;
            done_q <= 1'b0;
            pend_q <= 1'b0;
            ovf_q  <= 1'b0;
            pdat_q <= '0;
         end else begin
            if (wr_r3) r3_q <= trace_wbdata[g*32 +: 32];
            if (exit_ev && !done_q) begin
               done_q <= 1'b1;
               exit_q <= r3_q;
            end
            if (take) pend_q <= 1'b0;
            if (putc_ev) begin
               if (pend_q && !take) begin
                  ovf_q <= 1'b1;
               end else begin
                  pend_q <= 1'b1;
                  pdat_q <= r3_q[7:0];
               end
            end
         end
      end

      assign core_done[g]         = done_q;
      assign exit_code[g*32 +: 32] = exit_q;
      assign putc_overflow[g]     = ovf_q;
      assign pend[g]              = pend_q;
      assign pend_dat[g]          = pdat_q;
      assign err[g]               = done_q && (exit_q != '0);
   end

   trace_putc_arb #(.N(NUM_CORES)) u_arb (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear_i   (clear),
      .req_i     (pend),
      .accept_i  (accept),
      .gnt_o     (arb_gnt),
      .gnt_idx_o (arb_idx),
      .gnt_vld_o (arb_vld)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         char_vld_q  <= 1'b0;
         char_core_q <= '0;
         char_dat_q  <= '0;
      end else if (clear) begin
         char_vld_q  <= 1'b0;
         char_core_q <= '0;
         char_dat_q  <= '0;
      end else if (load) begin
         char_vld_q <= arb_vld;
         if (arb_vld) begin
            char_core_q <= arb_idx;
            char_dat_q  <= pend_dat[arb_idx];
         end
      end
   end

   always_comb begin
      done_count = '0;
      for (int i = 0; i < NUM_CORES; i++) done_count = done_count + DCW'(core_done[i]);
   end

   assign all_done  = &core_done;
   assign any_error = |err;

   // Counter value equals elapsed edges, so timeout lands exactly on edge TIMEOUT_CYCLES.
   assign wd_run = (TIMEOUT_CYCLES != 0) && !all_done && !timeout_q;
   assign wd_d   = wd_q + 32'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else if (clear) begin
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else if (wd_run) begin
         wd_q <= wd_d;
         if (wd_d == 32'(TIMEOUT_CYCLES)) timeout_q <= 1'b1;
      end
   end

   assign timeout    = timeout_q;
   assign char_valid = char_vld_q;
   assign char_core  = char_core_q;
   assign char_data  = char_dat_q;

endmodule

// File: tb/tb_trace_term_monitor.sv
// Directed bench for trace_term_monitor: exit, r3 shadow, putc arbitration, overflow, watchdog, clear.
module tb_trace_term_monitor;

   localparam logic [31:0] EXIT = 32'h1500_0001;
   localparam logic [31:0] PUTC = 32'h1500_0004;
   localparam logic [31:0] NOPK = 32'h1500_0000;
   localparam logic [31:0] ADDI = 32'h9c60_0000;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         clear;
   logic [3:0]   trace_valid;
   logic [127:0] trace_insn;
   logic [3:0]   trace_wben;
   logic [19:0]  trace_wbreg;
   logic [127:0] trace_wbdata;
   logic [3:0]   core_done;
   logic [127:0] exit_code;
   logic         all_done;
   logic         any_error;
   logic [2:0]   done_count;
   logic         timeout;
   logic         char_valid;
   logic         char_ready;
   logic [1:0]   char_core;
   logic [7:0]   char_data;
   logic [3:0]   putc_overflow;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   trace_term_monitor #(.NUM_CORES(4), .TIMEOUT_CYCLES(100)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .clear         (clear),
      .trace_valid   (trace_valid),
      .trace_insn    (trace_insn),
      .trace_wben    (trace_wben),
      .trace_wbreg   (trace_wbreg),
      .trace_wbdata  (trace_wbdata),
      .core_done     (core_done),
      .exit_code     (exit_code),
      .all_done      (all_done),
      .any_error     (any_error),
      .done_count    (done_count),
      .timeout       (timeout),
      .char_valid    (char_valid),
      .char_ready    (char_ready),
      .char_core     (char_core),
      .char_data     (char_data),
      .putc_overflow (putc_overflow)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      trace_valid  = '0;
      trace_insn   = '0;
      trace_wben   = '0;
      trace_wbreg  = '0;
      trace_wbdata = '0;
   endtask

   task automatic beat(input int c, input logic [31:0] insn, input logic wben,
                       input logic [4:0] wreg, input logic [31:0] data);
      trace_valid[c]          = 1'b1;
      trace_insn[c*32 +: 32]  = insn;
      trace_wben[c]           = wben;
      trace_wbreg[c*5 +: 5]   = wreg;
      trace_wbdata[c*32 +: 32] = data;
   endtask

   task automatic wr(input int c, input logic [31:0] data);
      beat(c, ADDI, 1'b1, 5'd3, data);
   endtask

   task automatic do_clear();
      idle();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL time_limit: got no finish, want finish");
      $fatal(1, "time limit");
   end

   initial begin
      rst_n = 1'b0;
      clear = 1'b0;
      char_ready = 1'b1;
      idle();
      repeat (2) step();
      chk("rst_done", 32'(core_done), 32'h0);
      chk("rst_ec", 32'(|exit_code), 32'h0);
      chk("rst_all", 32'(all_done), 32'h0);
      chk("rst_cnt", 32'(done_count), 32'h0);
      chk("rst_vld", 32'(char_valid), 32'h0);
      chk("rst_to", 32'(timeout), 32'h0);
      rst_n = 1'b1;

      // Watchdog: cores 0-2 exit early, core 3 stays running.
      for (int e = 1; e <= 100; e++) begin
         idle();
         if (e == 5) begin wr(0, 0); wr(1, 0); wr(2, 0); end
         if (e >= 6 && e <= 8) beat(e - 6, EXIT, 1'b0, 5'd0, 32'h0);
         step();
         if (e == 99) begin
            chk("to_e99", 32'(timeout), 32'h0);
            chk("to_cnt3", 32'(done_count), 32'd3);
         end
      end
      chk("to_e100", 32'(timeout), 32'h1);
      idle();
      repeat (5) step();
      chk("to_sticky", 32'(timeout), 32'h1);
      beat(3, EXIT, 1'b0, 5'd0, 32'h0);
      step();
      idle();
      chk("to_alldone", 32'(all_done), 32'h1);
      chk("to_after", 32'(timeout), 32'h1);

      // All four exit on cycles 10..13 after clear.
      do_clear();
      chk("clr_to", 32'(timeout), 32'h0);
      for (int c = 1; c <= 13; c++) begin
         idle();
         if (c == 2) for (int k = 0; k < 4; k++) wr(k, 0);
         if (c >= 10) beat(c - 10, EXIT, 1'b0, 5'd0, 32'h0);
         step();
         if (c == 12) begin
            chk("c12_all", 32'(all_done), 32'h0);
            chk("c12_cnt", 32'(done_count), 32'd3);
         end
      end
      idle();
      chk("c13_all", 32'(all_done), 32'h1);
      chk("c13_cnt", 32'(done_count), 32'd4);
      chk("c13_err", 32'(any_error), 32'h0);

      // First exit code is kept; non-r3 writes and other nop K are ignored.
      do_clear();
      wr(2, 32'h2A);
      step();
      idle();
      beat(2, EXIT, 1'b0, 5'd0, 32'h0);
      step();
      idle();
      chk("ec2", exit_code[95:64], 32'h2A);
      chk("done2", 32'(core_done), 32'h4);
      chk("err2", 32'(any_error), 32'h1);
      wr(2, 0);
      step();
      idle();
      beat(2, EXIT, 1'b0, 5'd0, 32'h0);
      step();
      idle();
      chk("ec2_kept", exit_code[95:64], 32'h2A);
      beat(1, ADDI, 1'b1, 5'd4, 32'h55);
      beat(0, NOPK, 1'b0, 5'd0, 32'h0);
      step();
      idle();
      beat(1, EXIT, 1'b0, 5'd0, 32'h0);
      step();
      idle();
      chk("ec1_r4", exit_code[63:32], 32'h0);
      chk("done_nopk", 32'(core_done), 32'h6);
      chk("cnt_2", 32'(done_count), 32'd2);

      // Same-cycle putc on cores 0,1,3 streams in core order.
      do_clear();
      char_ready = 1'b1;
      wr(0, 32'h61); wr(1, 32'h62); wr(3, 32'h63);
      step();
      idle();
      beat(0, PUTC, 1'b0, 5'd0, 32'h0);
      beat(1, PUTC, 1'b0, 5'd0, 32'h0);
      beat(3, PUTC, 1'b0, 5'd0, 32'h0);
      step();
      idle();
      chk("pc_lat", 32'(char_valid), 32'h0);
      step();
      chk("pc0_vld", 32'(char_valid), 32'h1);
      chk("pc0_core", 32'(char_core), 32'd0);
      chk("pc0_dat", 32'(char_data), 32'h61);
      step();
      chk("pc1_core", 32'(char_core), 32'd1);
      chk("pc1_dat", 32'(char_data), 32'h62);
      step();
      chk("pc3_core", 32'(char_core), 32'd3);
      chk("pc3_dat", 32'(char_data), 32'h63);
      step();
      chk("pc_drain", 32'(char_valid), 32'h0);
      beat(1, PUTC, 1'b0, 5'd0, 32'h0);
      step();
      idle();
      step();
      chk("rr_b", 32'(char_core), 32'd1);
      beat(1, PUTC, 1'b0, 5'd0, 32'h0);
      beat(3, PUTC, 1'b0, 5'd0, 32'h0);
      step();
      idle();
      step();
      chk("rr_first", 32'(char_core), 32'd3);
      chk("rr_first_d", 32'(char_data), 32'h63);
      step();
      chk("rr_second", 32'(char_core), 32'd1);

      // Backpressure: hold 'x', buffer 'y', drop 'z'.
      do_clear();
      char_ready = 1'b0;
      wr(1, 32'h78);
      step();
      idle();
      beat(1, PUTC, 1'b0, 5'd0, 32'h0);
      step();
      idle();
      wr(1, 32'h79);
      step();
      idle();
      chk("bp_x_vld", 32'(char_valid), 32'h1);
      chk("bp_x_dat", 32'(char_data), 32'h78);
      beat(1, PUTC, 1'b0, 5'd0, 32'h0);
      step();
      idle();
      chk("bp_y_noovf", 32'(putc_overflow), 32'h0);
      wr(1, 32'h7A);
      step();
      idle();
      beat(1, PUTC, 1'b0, 5'd0, 32'h0);
      step();
      idle();
      chk("bp_ovf", 32'(putc_overflow), 32'h2);
      chk("bp_hold", 32'(char_data), 32'h78);
      char_ready = 1'b1;
      step();
      chk("bp_y_vld", 32'(char_valid), 32'h1);
      chk("bp_y_dat", 32'(char_data), 32'h79);
      step();
      chk("bp_empty", 32'(char_valid), 32'h0);

      // Clear while a char is held and two cores are done.
      char_ready = 1'b0;
      wr(0, 32'h5); wr(2, 32'h7);
      step();
      idle();
      beat(0, EXIT, 1'b0, 5'd0, 32'h0);
      beat(2, EXIT, 1'b0, 5'd0, 32'h0);
      beat(1, PUTC, 1'b0, 5'd0, 32'h0);
      step();
      idle();
      step();
      chk("pre_vld", 32'(char_valid), 32'h1);
      chk("pre_cnt", 32'(done_count), 32'd2);
      do_clear();
      chk("cl_done", 32'(core_done), 32'h0);
      chk("cl_ec", 32'(|exit_code), 32'h0);
      chk("cl_err", 32'(any_error), 32'h0);
      chk("cl_cnt", 32'(done_count), 32'h0);
      chk("cl_vld", 32'(char_valid), 32'h0);
      chk("cl_core", 32'(char_core), 32'h0);
      chk("cl_dat", 32'(char_data), 32'h0);
      chk("cl_ovf", 32'(putc_overflow), 32'h0);
      beat(1, PUTC, 1'b0, 5'd0, 32'h0);
      step();
      idle();
      step();
      chk("cl_r3_vld", 32'(char_valid), 32'h1);
      chk("cl_r3_dat", 32'(char_data), 32'h0);

      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_vld", 32'(char_valid), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
